pipe_hazard_sched: RTL and testbench
====================================

Name: pipe_hazard_sched

Overview:
Central stall/flush scheduler for the 5-stage MIPS pipeline (F, D, E, M, W). It merges the hazard sources: load-use, fetch wait, data-memory wait, the multi-cycle divider and exceptions. From these it generates a per-stage stall (register enable, active-high) and flush (synchronous clear) for every pipeline register. It also sequences the iterative divider through an internal occupancy counter, so the divider needs no private FSM.

Parameters:
DIV_CYCLES, 32, number of cycles the divider occupies EX after start (legal 2..63)
CNT_W, 6, width of the divide counter (must satisfy 2^CNT_W > DIV_CYCLES)

Ports:
clk  in  1  system clock, all state on rising edge
resetn  in  1  synchronous, active-low reset
d_lwstall  in  1  load-use hazard detected in D
e_div_start  in  1  divide/modulo instruction valid in EX (level)
f_inst_ok  in  1  instruction SRAM-like data_ok pulse
m_mem_req  in  1  MEM stage holds a load/store awaiting data
m_data_ok  in  1  data SRAM-like data_ok pulse
m_except  in  1  exception/eret committed in MEM
stall_f, stall_d, stall_e, stall_m, stall_w  out  1 each  hold pipeline register
flush_d, flush_e, flush_m, flush_w  out  1 each  clear pipeline register (bubble)
flush_pc  out  1  redirect PC to exception vector/EPC this cycle
div_busy  out  1  divider iterating
div_done  out  1  one-cycle pulse, quotient/remainder valid in EX

Behaviour:
- Reset, sampled while resetn=0 at a clk edge: FSM=RUN, counter=0, inst_seen=0, data_seen=0.
- While resetn=0 combinationally: all stalls 0, flush_d..flush_w=1, flush_pc=0, div_busy=0, div_done=0.
- FSM states: RUN, DIV.
  - RUN->DIV when e_div_start=1 and not ex_flush. Counter loads DIV_CYCLES-1.
  - In DIV the counter decrements each cycle.
  - When the counter is 0 in DIV: div_done=1 that cycle, then DIV->RUN.
  - The divide source is inactive in that same cycle.
  - div_busy=1 exactly while in DIV.
  - Start seen at edge t -> div_done high in cycle t+DIV_CYCLES.
- e_div_start is ignored in the cycle after div_done: the EX instruction has advanced, so it cannot retrigger.
  - Implemented with a 1-cycle done_hold flag, cleared when stall_e=0.
- Wait flags:
  - inst_seen: set on f_inst_ok, cleared when stall_f=0.
  - fetch_wait = ~(f_inst_ok | inst_seen).
  - data_seen: set on m_data_ok while m_mem_req, cleared when stall_m=0.
  - mem_wait = m_mem_req & ~(m_data_ok | data_seen).
- Source reach, with stall[x] = OR of the sources reaching x:
  - mem_wait: F, D, E, M.
  - div (state DIV, counter≠0): F, D, E.
  - d_lwstall: F, D.
  - fetch_wait: F only.
- Bubble rule: flush[x+1] = stall[x] & ~stall[x+1], for x in F, D, E, M.
- Exception:
  - ex_flush = m_except & ~mem_wait. An exception never cancels an outstanding memory transaction; it is deferred until data_ok.
  - When ex_flush=1: flush_d, flush_e, flush_m, flush_w=1, flush_pc=1, and all stalls are 0, except stall_f=fetch_wait.
  - ex_flush aborts the divider: FSM->RUN, counter->0, div_done stays 0.
- Simultaneous events:
  - ex_flush beats div, lwstall and fetch_wait.
  - mem_wait beats ex_flush.
  - Reset beats everything.
- Reset mid-divide or mid-wait discards all state; no div_done is emitted.
- Stall/flush outputs are combinational from registered state plus inputs. No output-to-input combinational loop is permitted.

Decomposition:
- Shared package mips_pipe_pkg holds:
  - the FSM state encoding (RUN=1'b0, DIV=1'b1);
  - stage index constants ST_F..ST_W;
  - the default DIV_CYCLES.
- One sub-module, div_seq_counter: a loadable down-counter with zero flag, containing the RUN/DIV FSM. It is instantiated once.
- Stall/flush merge logic stays in the top.

Test Plan:
- Reset hold: resetn=0 for 3 cycles with d_lwstall=1 -> all stalls 0, flush_d..w=1; after release, FSM=RUN and div_busy=0.
- Divider timing, DIV_CYCLES=32: e_div_start held from edge t ->
  - stall_f/d/e=1 and flush_m=1 for cycles t+1..t+31;
  - div_done=1 only at t+32 with stalls 0;
  - no retrigger at t+33.
- Memory wait: m_mem_req=1 with m_data_ok 4 cycles late ->
  - stall_f..m=1 and flush_w=1 for 4 cycles;
  - on the data_ok cycle all stalls drop.
- Load-use: d_lwstall=1 for one cycle -> stall_f=stall_d=1, flush_e=1, stall_e=0.
- Exception during divide: m_except at counter=10 ->
  - flush_pc=1, flush_d..w=1;
  - next cycle div_busy=0, div_done never asserted.
- Exception during mem wait: m_except=1 and m_mem_req=1 with data_ok 2 cycles later ->
  - flush_pc stays 0 for 2 cycles;
  - flush_pc rises in the data_ok cycle.

Source files
------------

// File: rtl/pipe_hazard_sched_pkg.sv
// Shared pipeline scheduling types: divider FSM encoding, stage indices, default divide length.
package mips_pipe_pkg;

  typedef enum logic {
    RUN = 1'b0,
    DIV = 1'b1
  } div_state_e;

  localparam int ST_F = 0;
  localparam int ST_D = 1;
  localparam int ST_E = 2;
  localparam int ST_M = 3;
  localparam int ST_W = 4;

  localparam int DIV_CYCLES_DEF = 32;

endpackage

// File: rtl/pipe_hazard_sched_if.sv
// Hazard sources in, per-stage stall/flush and divider status out; all signals single-cycle levels.
interface pipe_hazard_sched_if;

  logic d_lwstall;
  logic e_div_start;
  logic f_inst_ok;
  logic m_mem_req;
  logic m_data_ok;
  logic m_except;

  logic stall_f, stall_d, stall_e, stall_m, stall_w;
  logic flush_d, flush_e, flush_m, flush_w;
  logic flush_pc;
  logic div_busy;
  logic div_done;

  modport master (
    output d_lwstall, e_div_start, f_inst_ok, m_mem_req, m_data_ok, m_except,
    input  stall_f, stall_d, stall_e, stall_m, stall_w,
    input  flush_d, flush_e, flush_m, flush_w, flush_pc, div_busy, div_done
  );

  modport slave (
    input  d_lwstall, e_div_start, f_inst_ok, m_mem_req, m_data_ok, m_except,
    output stall_f, stall_d, stall_e, stall_m, stall_w,
    output flush_d, flush_e, flush_m, flush_w, flush_pc, div_busy, div_done
  );

endinterface

// File: rtl/pipe_hazard_sched_div.sv
// Divider occupancy sequencer: RUN/DIV FSM with loadable down-counter; done is
// asserted in the zero-count cycle, DIV_CYCLES after the start edge, unless aborted.
module div_seq_counter
  import mips_pipe_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W      = 6
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic zero,
  output logic done
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (start) begin
          state_d = DIV;
          cnt_d   = CNT_W'(DIV_CYCLES - 1);
        end
      end
      DIV: begin
        if (abort || cnt_q == '0) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == DIV);
  assign zero = (cnt_q == '0);
  assign done = busy & zero & ~abort;

endmodule

// File: rtl/pipe_hazard_sched.sv
// Central stall/flush scheduler for the F/D/E/M/W pipeline; outputs are combinational
// from registered wait/divide state plus current hazard inputs, with no output-to-input path.
module pipe_hazard_sched
  import mips_pipe_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W      = 6
) (
  input  logic                clk,
  input  logic                resetn,
  pipe_hazard_sched_if.slave  hz
);

  logic inst_seen_q, inst_seen_d;
  logic data_seen_q, data_seen_d;
  logic done_hold_q, done_hold_d;

  logic fetch_wait, mem_wait, ex_flush;
  logic div_start, div_busy, div_zero, div_done, div_src;
  logic flush_pc;
  logic [ST_W:ST_F] stall;
  logic [ST_W:ST_D] flush;

  div_seq_counter #(
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_div_seq (
    .clk    (clk),
    .resetn (resetn),
    .start  (div_start),
    .abort  (ex_flush),
    .busy   (div_busy),
    .zero   (div_zero),
    .done   (div_done)
  );

  always_comb begin
    fetch_wait = ~(hz.f_inst_ok | inst_seen_q);
    mem_wait   = hz.m_mem_req & ~(hz.m_data_ok | data_seen_q);
    // An exception waits for any outstanding data access to complete.
    ex_flush   = hz.m_except & ~mem_wait;
    div_src    = div_busy & ~div_zero;
    // The EX instruction that just finished dividing must not restart the unit.
    div_start  = hz.e_div_start & ~ex_flush & ~done_hold_q;

    stall    = '0;
    flush    = '0;
    flush_pc = 1'b0;
    if (!resetn) begin
      flush = '1;
    end else if (ex_flush) begin
      stall[ST_F] = fetch_wait;
      flush       = '1;
      flush_pc    = 1'b1;
    end else begin
      stall[ST_F] = mem_wait | div_src | hz.d_lwstall | fetch_wait;
      stall[ST_D] = mem_wait | div_src | hz.d_lwstall;
      stall[ST_E] = mem_wait | div_src;
      stall[ST_M] = mem_wait;
      for (int x = ST_F; x < ST_W; x++) begin
        flush[x+1] = stall[x] & ~stall[x+1];
      end
    end

    inst_seen_d = stall[ST_F] & (inst_seen_q | hz.f_inst_ok);
    data_seen_d = stall[ST_M] & (data_seen_q | (hz.m_data_ok & hz.m_mem_req));
    done_hold_d = div_done | (stall[ST_E] & done_hold_q);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      inst_seen_q <= 1'b0;
      data_seen_q <= 1'b0;
      done_hold_q <= 1'b0;
    end else begin
      inst_seen_q <= inst_seen_d;
      data_seen_q <= data_seen_d;
      done_hold_q <= done_hold_d;
    end
  end

  assign hz.stall_f  = stall[ST_F];
  assign hz.stall_d  = stall[ST_D];
  assign hz.stall_e  = stall[ST_E];
  assign hz.stall_m  = stall[ST_M];
  assign hz.stall_w  = stall[ST_W];
  assign hz.flush_d  = flush[ST_D];
  assign hz.flush_e  = flush[ST_E];
  assign hz.flush_m  = flush[ST_M];
  assign hz.flush_w  = flush[ST_W];
  assign hz.flush_pc = flush_pc;
  assign hz.div_busy = resetn & div_busy;
  assign hz.div_done = resetn & div_done;

endmodule

// File: tb/tb_pipe_hazard_sched.sv
// Randomized and directed bench for pipe_hazard_sched against a reach-table reference model.
module tb_pipe_hazard_sched;
  import mips_pipe_pkg::*;

  localparam int DC = 32;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_sched_if hz ();

  pipe_hazard_sched #(.DIV_CYCLES(DC), .CNT_W(6)) dut (
    .clk    (clk),
    .resetn (resetn),
    .hz     (hz)
  );

  int n_chk = 0;
  int n_err = 0;
  string phase = "init";

  // Model state: m_left = cycles still owed by the divider including its done cycle.
  int m_left = 0;
  bit m_hold = 0, m_iseen = 0, m_dseen = 0;
  bit e_st[5];
  bit e_fl[5];
  bit e_pc, e_busy, e_done, e_exf;
  logic [11:0] obs, exp_v;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_outputs();
    bit fw, mw;
    bit src[4];
    int reach[4];
    fw    = !(hz.f_inst_ok || m_iseen);
    mw    = hz.m_mem_req && !(hz.m_data_ok || m_dseen);
    e_exf = hz.m_except && !mw;
    for (int x = 0; x < 5; x++) begin
      e_st[x] = 1'b0;
      e_fl[x] = 1'b0;
    end
    e_pc   = 1'b0;
    e_busy = (m_left > 0);
    e_done = 1'b0;
    if (!resetn) begin
      for (int x = 1; x < 5; x++) e_fl[x] = 1'b1;
      e_busy = 1'b0;
    end else if (e_exf) begin
      e_st[ST_F] = fw;
      for (int x = 1; x < 5; x++) e_fl[x] = 1'b1;
      e_pc = 1'b1;
    end else begin
      src   = '{mw, (m_left > 1), hz.d_lwstall, fw};
      reach = '{ST_M, ST_E, ST_D, ST_F};
      for (int s = 0; s < 4; s++)
        for (int x = 0; x < 5; x++)
          if (src[s] && x <= reach[s]) e_st[x] = 1'b1;
      for (int x = 1; x < 5; x++) e_fl[x] = e_st[x-1] && !e_st[x];
      e_done = (m_left == 1);
    end
  endtask

  task automatic model_advance();
    bit start_ok;
    if (!resetn) begin
      m_left = 0; m_hold = 0; m_iseen = 0; m_dseen = 0;
    end else begin
      start_ok = hz.e_div_start && !m_hold && !e_exf;
      m_iseen  = e_st[ST_F] && (m_iseen || hz.f_inst_ok);
      m_dseen  = e_st[ST_M] && (m_dseen || (hz.m_data_ok && hz.m_mem_req));
      if (e_exf) m_left = 0;
      else if (m_left > 0) m_left--;
      else if (start_ok) m_left = DC;
      m_hold = e_done || (e_st[ST_E] && m_hold);
    end
  endtask

  // obs bits: [11:7] stall_f..w, [6:3] flush_d..w, [2] flush_pc, [1] div_busy, [0] div_done
  task automatic step(input bit rn, input bit lw, input bit ds, input bit fok,
                      input bit mreq, input bit dok, input bit mexc);
    resetn         = rn;
    hz.d_lwstall   = lw;
    hz.e_div_start = ds;
    hz.f_inst_ok   = fok;
    hz.m_mem_req   = mreq;
    hz.m_data_ok   = dok;
    hz.m_except    = mexc;
    @(negedge clk);
    model_outputs();
    obs   = {hz.stall_f, hz.stall_d, hz.stall_e, hz.stall_m, hz.stall_w,
             hz.flush_d, hz.flush_e, hz.flush_m, hz.flush_w,
             hz.flush_pc, hz.div_busy, hz.div_done};
    exp_v = {e_st[0], e_st[1], e_st[2], e_st[3], e_st[4],
             e_fl[1], e_fl[2], e_fl[3], e_fl[4], e_pc, e_busy, e_done};
    check_eq(phase, obs, exp_v);
    @(posedge clk);
    model_advance();
    #1;
  endtask

  initial begin
    int cnt;
    bit ds, mreq;
    ds = 0; mreq = 0;
    @(posedge clk);
    #1;

    phase = "reset";
    repeat (3) begin
      step(0, 1, 0, 1, 0, 0, 0);
      check_eq("rst_outputs", obs, 12'b00000_1111_000);
    end
    step(1, 0, 0, 1, 0, 0, 0);
    check_eq("post_rst_busy", obs[1], 1'b0);
    check_eq("post_rst_stalls", obs[11:7], 5'b0);

    phase = "div";
    step(1, 0, 1, 1, 0, 0, 0);
    cnt = 0;
    for (int k = 1; k < DC; k++) begin
      step(1, 0, 1, 1, 0, 0, 0);
      if (obs[11:7] == 5'b11100 && obs[4] && !obs[0]) cnt++;
    end
    check_eq("div_stall_cycles", cnt, DC - 1);
    step(1, 0, 1, 1, 0, 0, 0);
    check_eq("div_done_pulse", obs[0], 1'b1);
    check_eq("div_done_stalls", obs[11:7], 5'b0);
    step(1, 0, 1, 1, 0, 0, 0);
    check_eq("div_after_done", obs[1:0], 2'b00);
    step(1, 0, 0, 1, 0, 0, 0);
    check_eq("div_no_retrigger", obs[1], 1'b0);

    phase = "memwait";
    cnt = 0;
    repeat (4) begin
      step(1, 0, 0, 1, 1, 0, 0);
      if (obs[11:7] == 5'b11110 && obs[3]) cnt++;
    end
    check_eq("mem_wait_cycles", cnt, 4);
    step(1, 0, 0, 1, 1, 1, 0);
    check_eq("mem_ok_stalls", obs[11:7], 5'b0);
    step(1, 0, 0, 1, 0, 0, 0);

    phase = "loaduse";
    step(1, 1, 0, 1, 0, 0, 0);
    check_eq("lw_stalls", obs[11:9], 3'b110);
    check_eq("lw_flush_e", obs[5], 1'b1);
    step(1, 0, 0, 1, 0, 0, 0);

    phase = "exc_div";
    step(1, 0, 1, 1, 0, 0, 0);
    repeat (21) step(1, 0, 1, 1, 0, 0, 0);
    step(1, 0, 1, 1, 0, 0, 1);
    check_eq("exc_div_pc", obs[2], 1'b1);
    check_eq("exc_div_flush", obs[6:3], 4'hf);
    step(1, 0, 0, 1, 0, 0, 0);
    check_eq("exc_div_busy", obs[1], 1'b0);
    cnt = 0;
    repeat (40) begin
      step(1, 0, 0, 1, 0, 0, 0);
      if (obs[0]) cnt++;
    end
    check_eq("exc_div_no_done", cnt, 0);

    phase = "exc_mem";
    step(1, 0, 0, 1, 1, 0, 1);
    check_eq("exc_mem_pc0", obs[2], 1'b0);
    step(1, 0, 0, 1, 1, 0, 1);
    check_eq("exc_mem_pc1", obs[2], 1'b0);
    step(1, 0, 0, 1, 1, 1, 1);
    check_eq("exc_mem_pc2", obs[2], 1'b1);
    step(1, 0, 0, 1, 0, 0, 0);

    phase = "random";
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) ds = ~ds;
      if ($urandom_range(0, 5) == 0) mreq = ~mreq;
      step($urandom_range(0, 199) != 0,
           $urandom_range(0, 5) == 0,
           ds,
           $urandom_range(0, 1) == 1,
           mreq,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 29) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
